fetch_unit: RTL and testbench

Parametrised instruction fetch stage for the myMIPS-class cores. It replaces the bare PC register and ROM read enable with a decoupled front end. It issues reads to the synchronous instruction ROM, buffers {pc, instr} pairs in a small prefetch FIFO, and hands them to decode over a valid/ready handshake. It supports control-flow redirects (branch/jump resolution) with flush of all stale fetches, and a halt input.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the myMIPS-class cores: default fetch geometry,
// the reset fetch address and the NOP encoding.
package cpu_pkg;

  localparam int CPU_AWIDTH   = 8;
  localparam int CPU_IWIDTH   = 16;
  localparam int CPU_RESET_PC = 0;
  // All-zero word doubles as the "nothing here" value on empty outputs.
  localparam int CPU_NOP      = 0;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous flush and an occupancy count.
// head_data reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    wr_en    = push & ~flush;
    rd_en    = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && count_q == CW'(DEPTH)))
        else $error("sync_fifo overflow");
    end
  end

  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: issues synchronous ROM reads, buffers
// {pc, instr} pairs in a prefetch FIFO and supports redirect flush and halt.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                AWIDTH   = CPU_AWIDTH,
  parameter int                IWIDTH   = CPU_IWIDTH,
  parameter int                DEPTH    = 4,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(CPU_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    rom_rd,
  output logic [AWIDTH-1:0]       rom_raddr,
  input  logic [IWIDTH-1:0]       rom_rdata,
  input  logic                    redir_valid,
  input  logic [AWIDTH-1:0]       redir_pc,
  input  logic                    halt,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [IWIDTH-1:0]       o_instr,
  output logic [AWIDTH-1:0]       o_pc,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WIDTH = AWIDTH + IWIDTH;

  logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;

  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic [WIDTH-1:0]  fifo_head;
  logic              issue, push, pop;

  // The read in flight reserves a slot; a same-cycle pop is not credited.
  always_comb begin
    occupancy = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
    issue     = ~rst & ~halt & ~redir_valid & (occupancy < (CW + 1)'(DEPTH));
    push      = inflight_q & ~redir_valid;
    pop       = o_valid & o_ready;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redir_valid) begin
      fetch_pc_d = redir_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + AWIDTH'(1);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir_valid),
    .push      (push),
    .push_data ({inflight_pc_q, rom_rdata}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign rom_rd    = issue;
  assign rom_raddr = fetch_pc_q;
  assign o_valid   = (fifo_count != '0);
  assign o_pc      = o_valid ? fifo_head[WIDTH-1 -: AWIDTH] : '0;
  assign o_instr   = o_valid ? fifo_head[IWIDTH-1:0] : IWIDTH'(CPU_NOP);
  assign o_count   = fifo_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_rd;
  logic [7:0]  rom_raddr;
  logic [15:0] rom_rdata = 16'h0;
  logic        redir_valid = 1'b0;
  logic [7:0]  redir_pc = 8'h0;
  logic        halt = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [15:0] o_instr;
  logic [7:0]  o_pc;
  logic [2:0]  o_count;

  fetch_unit #(.AWIDTH(8), .IWIDTH(16), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .rom_rd(rom_rd), .rom_raddr(rom_raddr),
    .rom_rdata(rom_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt(halt), .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr),
    .o_pc(o_pc), .o_count(o_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  // Synchronous ROM; garbage on the data bus whenever no read was issued.
  always @(posedge clk) rom_rdata <= rom_rd ? rom_word(rom_raddr) : 16'($urandom);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending entries, fetch pointer, outstanding read.
  logic [23:0] mq[$];
  logic [23:0] deliv[$];
  logic [7:0]  m_pc = 8'h00;
  logic [7:0]  m_inf_pc = 8'h00;
  int          m_inf = 0;
  bit          m_init = 0;

  logic        s_rd, s_valid;
  logic [7:0]  s_addr, s_pc;
  logic [15:0] s_instr;
  logic [2:0]  s_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic rv,
                      input logic [7:0] rp, input logic rdy);
    logic e_rd;
    @(negedge clk);
    rst = r; halt = h; redir_valid = rv; redir_pc = rp; o_ready = rdy;
    #1;
    s_rd = rom_rd; s_addr = rom_raddr; s_valid = o_valid;
    s_pc = o_pc; s_instr = o_instr; s_count = o_count;
    e_rd = !r && !h && !rv && ((mq.size() + m_inf) < DEPTH);
    if (m_init) begin
      check("rom_rd", 32'(s_rd), 32'(e_rd));
      check("rom_raddr", 32'(s_addr), 32'(m_pc));
      check("o_valid", 32'(s_valid), 32'(mq.size() != 0));
      check("o_pc", 32'(s_pc), (mq.size() != 0) ? 32'(mq[0][23:16]) : 32'h0);
      check("o_instr", 32'(s_instr), (mq.size() != 0) ? 32'(mq[0][15:0]) : 32'h0);
      check("o_count", 32'(s_count), 32'(mq.size()));
    end
    if (!r && s_valid && rdy) deliv.push_back({s_pc, s_instr});
    if (r) begin
      mq.delete(); m_inf = 0; m_pc = 8'h00; m_init = 1;
    end else if (rv) begin
      mq.delete(); m_inf = 0; m_pc = rp;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_inf != 0) mq.push_back({m_inf_pc, rom_word(m_inf_pc)});
      m_inf = e_rd ? 1 : 0;
      if (e_rd) begin
        m_inf_pc = m_pc;
        m_pc = m_pc + 8'h01;
      end
    end
  endtask

  task automatic run(input int n, input logic h, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, h, 1'b0, 8'h00, rdy);
  endtask

  initial begin
    int nrd, bad;
    bit saw_rd;

    // 1: reset state, then back-to-back streaming from pc 0
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 1);
    check("rst_valid", 32'(s_valid), 0);
    check("rst_count", 32'(s_count), 0);
    check("rst_rd", 32'(s_rd), 0);
    check("rst_pc", 32'(s_pc), 0);
    check("rst_instr", 32'(s_instr), 0);
    deliv.delete();
    step(0, 0, 0, 8'h00, 1);
    check("t1_rd0", 32'(s_rd), 1);
    check("t1_addr0", 32'(s_addr), 32'h00);
    step(0, 0, 0, 8'h00, 1);
    check("t1_valid1", 32'(s_valid), 0);
    step(0, 0, 0, 8'h00, 1);
    check("t1_pc2", 32'(s_pc), 32'h00);
    check("t1_instr2", 32'(s_instr), 32'h1000);
    step(0, 0, 0, 8'h00, 1);
    check("t1_instr3", 32'(s_instr), 32'h1001);
    step(0, 0, 0, 8'h00, 1);
    check("t1_instr4", 32'(s_instr), 32'h1002);
    run(10, 0, 1);
    check("t1_ndeliv", deliv.size(), 13);
    bad = 0;
    foreach (deliv[k]) if (deliv[k] != {8'(k), 16'h1000 + 16'(k)}) bad++;
    check("t1_stream", bad, 0);

    // 2: decode stalled after reset fills exactly DEPTH entries
    step(1, 0, 0, 8'h00, 0);
    nrd = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 8'h00, 0);
      nrd += int'(s_rd);
    end
    check("t2_reads", nrd, 4);
    check("t2_count", 32'(s_count), 4);
    check("t2_rd_off", 32'(s_rd), 0);
    deliv.delete();
    step(0, 0, 0, 8'h00, 1);
    check("t2_pop_no_credit", 32'(s_rd), 0);
    saw_rd = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 8'h00, 1);
      saw_rd |= s_rd;
    end
    check("t2_resume", 32'(saw_rd), 1);
    bad = 0;
    for (int k = 0; k < 4; k++) if (deliv.size() <= k || deliv[k][23:16] != 8'(k)) bad++;
    check("t2_order", bad, 0);

    // 3: redirect with 3 buffered entries and one read in flight
    step(1, 0, 0, 8'h00, 0);
    run(4, 0, 0);
    step(0, 0, 1, 8'h40, 0);
    check("t3_pre_count", 32'(s_count), 3);
    deliv.delete();
    step(0, 0, 0, 8'h00, 1);
    check("t3_flush_valid", 32'(s_valid), 0);
    check("t3_flush_count", 32'(s_count), 0);
    check("t3_raddr", 32'(s_addr), 32'h40);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    check("t3_pc", 32'(s_pc), 32'h40);
    check("t3_instr", 32'(s_instr), 32'h1040);
    run(6, 0, 1);
    bad = 0;
    foreach (deliv[k]) if (deliv[k][23:16] >= 8'h04 && deliv[k][23:16] <= 8'h07) bad++;
    check("t3_no_stale", bad, 0);

    // 4: redirect near the top of the address space wraps to 0
    step(0, 0, 1, 8'hFE, 1);
    deliv.delete();
    run(7, 0, 1);
    if (deliv.size() < 4) check("t4_ndeliv", deliv.size(), 4);
    else begin
      check("t4_e0", deliv[0], 24'hFE10FE);
      check("t4_e1", deliv[1], 24'hFF10FF);
      check("t4_e2", deliv[2], 24'h001000);
      check("t4_e3", deliv[3], 24'h011001);
    end

    // 5: redirect under halt; fetch resumes at target when halt drops
    run(3, 0, 0);
    saw_rd = 0;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 8'h00, 1);
      saw_rd |= s_rd;
    end
    step(0, 1, 1, 8'h10, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h00, 1);
      saw_rd |= s_rd;
    end
    check("t5_halt_rd", 32'(saw_rd), 0);
    check("t5_empty", 32'(s_count), 0);
    deliv.delete();
    step(0, 0, 0, 8'h00, 1);
    check("t5_rd", 32'(s_rd), 1);
    check("t5_raddr", 32'(s_addr), 32'h10);
    run(3, 0, 1);
    check("t5_first", (deliv.size() > 0) ? 32'(deliv[0][23:16]) : 32'hFFFF, 32'h10);

    // 6: reset with a full FIFO discards everything
    run(8, 0, 0);
    check("t6_full", 32'(s_count), 4);
    step(1, 0, 0, 8'h00, 0);
    deliv.delete();
    step(0, 0, 0, 8'h00, 1);
    check("t6_valid", 32'(s_valid), 0);
    check("t6_count", 32'(s_count), 0);
    check("t6_raddr", 32'(s_addr), 32'h00);
    run(4, 0, 1);
    check("t6_restart", (deliv.size() > 1) ? 32'(deliv[1][23:16]) : 32'hFFFF, 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) == 0), ($urandom_range(4) == 0),
           ($urandom_range(19) == 0), 8'($urandom), ($urandom_range(2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
